// File: rtl/csi_2_rx_byte_aligner.sv
// CSI-2 D-PHY HS byte aligner: hunts a 16-bit sliding window for the leader sync byte,
// then emits payload bytes re-aligned to the bit offset where sync was found.
module csi_2_rx_byte_aligner #(
    parameter logic [7:0]  SYNC_WORD  = 8'hB8,
    parameter int unsigned HUNT_LIMIT = 32
) (
    input  logic       RxByteClkHS,
    input  logic       ResetN,
    input  logic       Shutdown,
    input  logic       RxActiveIn,
    input  logic       RawValid,
    input  logic [7:0] RawByte,
    output logic [7:0] RxByteHS,
    output logic       RxValidHS,
    output logic       RxSyncHS,
    output logic       RxActiveHS,
    output logic       ErrSotHS,
    output logic       ErrSotSyncHS
);

    typedef enum logic [1:0] {StIdle, StHunt, StLocked, StWaitEnd} alignStateT;

    alignStateT  state;
    logic [7:0]  prevByte;
    logic [2:0]  offset;
    logic [7:0]  huntCnt;

    logic [15:0] window;
    logic [7:0]  alignedByte;
    logic [7:0]  diff;
    logic        exactHit;
    logic [2:0]  exactK;
    logic        errHit;
    logic [2:0]  errK;
    logic [7:0]  huntCntInc;
    logic        huntExpired;

    // PrevByte holds the earlier byte, so its bits are the older (lower) half of the window.
    assign window      = {RawByte, prevByte};
    assign alignedByte = window[offset +: 8];

    // Scan high-to-low so the lowest matching offset is the one left standing.
    always_comb begin
        exactHit = 1'b0;
        exactK   = 3'd0;
        errHit   = 1'b0;
        errK     = 3'd0;
        diff     = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            diff = window[k +: 8] ^ SYNC_WORD;
            if (diff == 8'h00) begin
                exactHit = 1'b1;
                exactK   = 3'(k);
            end
            if ((diff != 8'h00) && ((diff & (diff - 8'd1)) == 8'h00)) begin
                errHit = 1'b1;
                errK   = 3'(k);
            end
        end
    end

    assign huntCntInc  = (huntCnt == 8'hFF) ? huntCnt : huntCnt + 8'd1;
    assign huntExpired = ({24'd0, huntCntInc} >= HUNT_LIMIT);

    always_ff @(posedge RxByteClkHS or negedge ResetN) begin
        if (!ResetN) begin
            state        <= StIdle;
            prevByte     <= 8'h00;
            offset       <= 3'd0;
            huntCnt      <= 8'h00;
            RxByteHS     <= 8'h00;
            RxValidHS    <= 1'b0;
            RxSyncHS     <= 1'b0;
            RxActiveHS   <= 1'b0;
            ErrSotHS     <= 1'b0;
            ErrSotSyncHS <= 1'b0;
        end else if (Shutdown) begin
            state        <= StIdle;
            prevByte     <= 8'h00;
            offset       <= 3'd0;
            huntCnt      <= 8'h00;
            RxByteHS     <= 8'h00;
            RxValidHS    <= 1'b0;
            RxSyncHS     <= 1'b0;
            RxActiveHS   <= 1'b0;
            ErrSotHS     <= 1'b0;
            ErrSotSyncHS <= 1'b0;
        end else begin
            RxValidHS    <= 1'b0;
            RxSyncHS     <= 1'b0;
            ErrSotHS     <= 1'b0;
            ErrSotSyncHS <= 1'b0;
            unique case (state)
                StIdle: begin
                    RxActiveHS <= 1'b0;
                    if (RxActiveIn) begin
                        state    <= StHunt;
                        huntCnt  <= 8'h00;
                        prevByte <= 8'h00;
                    end
                end
                StHunt: begin
                    if (!RxActiveIn) begin
                        state      <= StIdle;
                        RxActiveHS <= 1'b0;
                    end else if (RawValid) begin
                        prevByte <= RawByte;
                        if (exactHit) begin
                            offset     <= exactK;
                            state      <= StLocked;
                            RxSyncHS   <= 1'b1;
                            RxActiveHS <= 1'b1;
                        end else if (errHit) begin
                            offset     <= errK;
                            state      <= StLocked;
                            RxSyncHS   <= 1'b1;
                            ErrSotHS   <= 1'b1;
                            RxActiveHS <= 1'b1;
                        end else begin
                            huntCnt <= huntCntInc;
                            if (huntExpired) begin
                                state        <= StWaitEnd;
                                ErrSotSyncHS <= 1'b1;
                            end
                        end
                    end
                end
                StLocked: begin
                    // A byte arriving with RxActiveIn low belongs to no burst and is dropped.
                    if (!RxActiveIn) begin
                        state      <= StIdle;
                        RxActiveHS <= 1'b0;
                    end else if (RawValid) begin
                        prevByte  <= RawByte;
                        RxByteHS  <= alignedByte;
                        RxValidHS <= 1'b1;
                    end
                end
                StWaitEnd: begin
                    if (!RxActiveIn) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state      <= StIdle;
                    RxActiveHS <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi_2_rx_byte_aligner.sv
// Directed bench for csi_2_rx_byte_aligner: each driven cycle queues the expected outputs
// for the following edge, and a checker process pops and compares them.
module tb_csi_2_rx_byte_aligner;

    logic       RxByteClkHS = 1'b0;
    logic       ResetN;
    logic       Shutdown;
    logic       RxActiveIn;
    logic       RawValid;
    logic [7:0] RawByte;
    logic [7:0] RxByteHS;
    logic       RxValidHS;
    logic       RxSyncHS;
    logic       RxActiveHS;
    logic       ErrSotHS;
    logic       ErrSotSyncHS;

    typedef struct {
        logic [12:0] vec;
        string       tag;
    } expT;

    expT        expQ[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] heldByte = 8'h00;

    // {active, valid, sync, errSot, errSotSync}
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_VLD  = 5'b11000;
    localparam logic [4:0] F_SYNC = 5'b10100;
    localparam logic [4:0] F_SERR = 5'b10110;
    localparam logic [4:0] F_TOUT = 5'b00001;

    csi_2_rx_byte_aligner #(
        .SYNC_WORD  (8'hB8),
        .HUNT_LIMIT (32)
    ) dut (
        .RxByteClkHS  (RxByteClkHS),
        .ResetN       (ResetN),
        .Shutdown     (Shutdown),
        .RxActiveIn   (RxActiveIn),
        .RawValid     (RawValid),
        .RawByte      (RawByte),
        .RxByteHS     (RxByteHS),
        .RxValidHS    (RxValidHS),
        .RxSyncHS     (RxSyncHS),
        .RxActiveHS   (RxActiveHS),
        .ErrSotHS     (ErrSotHS),
        .ErrSotSyncHS (ErrSotSyncHS)
    );

    always #5 RxByteClkHS = ~RxByteClkHS;

    function automatic logic [12:0] observed();
        return {RxActiveHS, RxValidHS, RxSyncHS, ErrSotHS, ErrSotSyncHS, RxByteHS};
    endfunction

    always begin
        expT e;
        logic [12:0] obs;
        @(posedge RxByteClkHS);
        #2;
        if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = observed();
            checks++;
            assert (obs === e.vec) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.vec);
            end
        end
    end

    // Called on a falling edge; drives one cycle of inputs and queues the outcome.
    task automatic step(input logic act, input logic vld, input logic [7:0] b, input logic sd,
                        input logic [4:0] flags, input logic [7:0] eByte, input string tag);
        expT e;
        RxActiveIn = act;
        RawValid   = vld;
        RawByte    = b;
        Shutdown   = sd;
        if (sd) heldByte = 8'h00;
        else if (flags[3]) heldByte = eByte;
        e.vec = {flags, heldByte};
        e.tag = tag;
        expQ.push_back(e);
        @(negedge RxByteClkHS);
    endtask

    task automatic checkNow(input logic [12:0] expVec, input string tag);
        logic [12:0] obs;
        obs = observed();
        checks++;
        assert (obs === expVec) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expVec);
        end
    endtask

    initial begin
        ResetN     = 1'b0;
        Shutdown   = 1'b0;
        RxActiveIn = 1'b0;
        RawValid   = 1'b0;
        RawByte    = 8'h00;
        #1;
        checkNow(13'h0000, "reset_state");
        @(negedge RxByteClkHS);
        ResetN = 1'b1;

        // Offset 0: sync B8 becomes PrevByte on the next byte, then 12,34,56 stream out.
        step(1, 0, 8'h00, 0, F_NONE, 8'h00, "o0_enter_hunt");
        step(1, 1, 8'h00, 0, F_NONE, 8'h00, "o0_byte00");
        step(1, 1, 8'hB8, 0, F_NONE, 8'h00, "o0_byteB8");
        step(1, 1, 8'h12, 0, F_SYNC, 8'h00, "o0_sync");
        step(1, 1, 8'h34, 0, F_VLD,  8'h12, "o0_out12");
        step(1, 0, 8'hFF, 0, 5'b10000, 8'h00, "o0_gap");
        step(1, 1, 8'h56, 0, F_VLD,  8'h34, "o0_out34");
        step(1, 1, 8'h78, 0, F_VLD,  8'h56, "o0_out56");
        step(0, 1, 8'h9A, 0, F_NONE, 8'h00, "o0_end_drop");
        step(0, 0, 8'h00, 0, F_NONE, 8'h00, "o0_idle");

        // Offset 3: sync straddles C0/95.
        step(1, 0, 8'h00, 0, F_NONE, 8'h00, "o3_enter_hunt");
        step(1, 1, 8'hC0, 0, F_NONE, 8'h00, "o3_byteC0");
        step(1, 1, 8'h95, 0, F_SYNC, 8'h00, "o3_sync");
        step(1, 1, 8'hA0, 0, F_VLD,  8'h12, "o3_out12");
        step(1, 1, 8'h05, 0, F_VLD,  8'hB4, "o3_outB4");
        step(0, 0, 8'h00, 0, F_NONE, 8'h00, "o3_end");

        // Single-bit error in the leader at offset 0.
        step(1, 0, 8'h00, 0, F_NONE, 8'h00, "se_enter_hunt");
        step(1, 1, 8'h00, 0, F_NONE, 8'h00, "se_byte00");
        step(1, 1, 8'hB9, 0, F_NONE, 8'h00, "se_byteB9");
        step(1, 1, 8'h12, 0, F_SERR, 8'h00, "se_sync_err");
        step(1, 1, 8'h34, 0, F_VLD,  8'h12, "se_out12");
        step(1, 1, 8'h56, 0, F_VLD,  8'h34, "se_out34");
        step(0, 0, 8'h00, 0, F_NONE, 8'h00, "se_end");

        // Window 2E38: one-bit match at offset 0, exact at offset 6; exact must win.
        step(1, 0, 8'h00, 0, F_NONE, 8'h00, "pr_enter_hunt");
        step(1, 1, 8'h38, 0, F_NONE, 8'h00, "pr_byte38");
        step(1, 1, 8'h2E, 0, F_SYNC, 8'h00, "pr_sync_exact");
        step(1, 1, 8'h15, 0, F_VLD,  8'h54, "pr_out54_off6");
        step(0, 0, 8'h00, 0, F_NONE, 8'h00, "pr_end");

        // Timeout after 32 valid bytes; an idle gap in between is not counted.
        step(1, 0, 8'h00, 0, F_NONE, 8'h00, "to_enter_hunt");
        for (int i = 0; i < 31; i++) begin
            step(1, 1, 8'h00, 0, F_NONE, 8'h00, "to_hunt_byte");
            if (i == 15) step(1, 0, 8'h00, 0, F_NONE, 8'h00, "to_hunt_gap");
        end
        step(1, 1, 8'h00, 0, F_TOUT, 8'h00, "to_err_sot_sync");
        step(1, 1, 8'hB8, 0, F_NONE, 8'h00, "to_wait_B8");
        step(1, 1, 8'h12, 0, F_NONE, 8'h00, "to_wait_12");
        step(0, 0, 8'h00, 0, F_NONE, 8'h00, "to_drop_active");
        step(1, 0, 8'h00, 0, F_NONE, 8'h00, "to_rehunt");
        step(1, 1, 8'hB8, 0, F_NONE, 8'h00, "to_rehunt_B8");
        step(1, 1, 8'h12, 0, F_SYNC, 8'h00, "to_relock_sync");
        step(1, 1, 8'h34, 0, F_VLD,  8'h12, "to_relock_out12");

        // Shutdown while locked, then relock.
        step(1, 1, 8'h56, 1, F_NONE, 8'h00, "sd_clear");
        step(1, 0, 8'h00, 0, F_NONE, 8'h00, "sd_enter_hunt");
        step(1, 1, 8'h00, 0, F_NONE, 8'h00, "sd_byte00");
        step(1, 1, 8'hB8, 0, F_NONE, 8'h00, "sd_byteB8");
        step(1, 1, 8'h12, 0, F_SYNC, 8'h00, "sd_sync");
        step(1, 1, 8'h34, 0, F_VLD,  8'h12, "sd_out12");

        // Asynchronous reset while locked; outputs clear before any clock edge.
        ResetN     = 1'b0;
        RxActiveIn = 1'b1;
        RawValid   = 1'b1;
        RawByte    = 8'h56;
        #1;
        heldByte = 8'h00;
        checkNow(13'h0000, "ar_immediate");
        @(negedge RxByteClkHS);
        checkNow(13'h0000, "ar_held");
        ResetN = 1'b1;
        step(0, 1, 8'hB8, 0, F_NONE, 8'h00, "ar_idle_B8");
        step(0, 1, 8'h12, 0, F_NONE, 8'h00, "ar_idle_12");
        step(1, 0, 8'h00, 0, F_NONE, 8'h00, "ar_enter_hunt");
        step(1, 1, 8'h00, 0, F_NONE, 8'h00, "ar_byte00");
        step(1, 1, 8'hB8, 0, F_NONE, 8'h00, "ar_byteB8");
        step(1, 1, 8'h12, 0, F_SYNC, 8'h00, "ar_sync");
        step(1, 1, 8'h34, 0, F_VLD,  8'h12, "ar_out12");
        step(0, 0, 8'h00, 0, F_NONE, 8'h00, "ar_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
